// File: rtl/peripheral_wb_pkg.sv
// Shared Wishbone B4 definitions: cycle/burst type codes, the RAM state type and
// the registered-feedback next-address helper.
package peripheral_wb_pkg;

   localparam int unsigned WB_ADR_W = 32;

   localparam logic [2:0] CTI_CLASSIC      = 3'b000;
   localparam logic [2:0] CTI_CONST_BURST  = 3'b001;
   localparam logic [2:0] CTI_INC_BURST    = 3'b010;
   localparam logic [2:0] CTI_END_OF_BURST = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP_4  = 2'b01;
   localparam logic [1:0] BTE_WRAP_8  = 2'b10;
   localparam logic [1:0] BTE_WRAP_16 = 2'b11;

   typedef enum logic [1:0] {IDLE, CLASSIC, BURST} wb_ram_state_t;

   // Address of the beat following adr; wrap bursts keep the upper word bits.
   function automatic logic [WB_ADR_W-1:0] wb_next_adr(input logic [WB_ADR_W-1:0] adr,
                                                       input logic [2:0] cti,
                                                       input logic [1:0] bte,
                                                       input int unsigned dw);
      int unsigned shift;
      logic [WB_ADR_W-1:0] word;
      logic [WB_ADR_W-1:0] inc;
      logic [WB_ADR_W-1:0] mask;
      shift = $clog2(dw / 8);
      word  = adr >> shift;
      inc   = word + WB_ADR_W'(1);
      case (bte)
         BTE_WRAP_4:  mask = WB_ADR_W'(3);
         BTE_WRAP_8:  mask = WB_ADR_W'(7);
         BTE_WRAP_16: mask = WB_ADR_W'(15);
         default:     mask = '1;
      endcase
      if (cti == CTI_INC_BURST)
         word = (word & ~mask) | (inc & mask);
      return (word << shift) | (adr & ((WB_ADR_W'(1) << shift) - WB_ADR_W'(1)));
   endfunction

endpackage

// File: rtl/peripheral_wb_ram_mem.sv
// Byte-enable RAM array with a registered read port and write-first bypass
// between the committing beat and the lookahead read.
module peripheral_wb_ram_mem #(
   parameter int unsigned DW    = 32,
   parameter int unsigned DEPTH = 256
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DW/8-1:0]            we,
   input  logic [$clog2(DEPTH)-1:0]   wadr,
   input  logic [DW-1:0]              wdat,
   input  logic                       re,
   input  logic                       clr,
   input  logic [$clog2(DEPTH)-1:0]   radr,
   output logic [DW-1:0]              rdat
);

   localparam int unsigned SW = DW / 8;

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] fwd;

   always_ff @(posedge clk) begin
      for (int b = 0; b < SW; b++)
         if (we[b]) mem[wadr][8*b +: 8] <= wdat[8*b +: 8];
   end

   // Bytes being written this edge override the stale array contents.
   always_comb begin
      fwd = mem[radr];
      for (int b = 0; b < SW; b++)
         if (we[b] && (wadr == radr)) fwd[8*b +: 8] = wdat[8*b +: 8];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      rdat <= '0;
      else if (clr) rdat <= '0;
      else if (re)  rdat <= fwd;
   end

endmodule

// File: rtl/peripheral_wb_burst_ram.sv
// Wishbone B4 registered-feedback burst RAM slave (classic, const, linear/wrap bursts).
// Optional PERIPHERAL_WB_RAM_ERR_EN: out-of-range word addresses answer with err.
module peripheral_wb_burst_ram
   import peripheral_wb_pkg::*;
#(
   parameter int unsigned AW    = 32,
   parameter int unsigned DW    = 32,
   parameter int unsigned DEPTH = 256
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic [AW-1:0]   wb_adr_i,
   input  logic [DW-1:0]   wb_dat_i,
   input  logic [DW/8-1:0] wb_sel_i,
   input  logic            wb_we_i,
   input  logic            wb_cyc_i,
   input  logic            wb_stb_i,
   input  logic [2:0]      wb_cti_i,
   input  logic [1:0]      wb_bte_i,
   output logic [DW-1:0]   wb_dat_o,
   output logic            wb_ack_o,
   output logic            wb_err_o,
   output logic            wb_rty_o
);

   localparam int unsigned SW      = DW / 8;
   localparam int unsigned ADR_LSB = $clog2(SW);
   localparam int unsigned IW      = $clog2(DEPTH);

   wb_ram_state_t state, state_nxt;
   logic          ack_nxt, err_nxt;
   logic          rd_en, rd_clr;
   logic          accept, adr_oor, nadr_oor;
   logic [AW-1:0] nadr, rd_adr;
   logic [SW-1:0] wr_be;
   logic          unused_adr;

   assign nadr   = AW'(wb_next_adr(WB_ADR_W'(wb_adr_i), wb_cti_i, wb_bte_i, DW));
   assign accept = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;

`ifdef PERIPHERAL_WB_RAM_ERR_EN
   assign adr_oor  = (wb_adr_i >> ADR_LSB) >= AW'(DEPTH);
   assign nadr_oor = (nadr >> ADR_LSB) >= AW'(DEPTH);
`else
   assign adr_oor  = 1'b0;
   assign nadr_oor = 1'b0;
`endif

   // A beat commits only on the edge that completes it (ack & cyc & stb).
   assign wr_be      = (wb_ack_o & wb_cyc_i & wb_stb_i & wb_we_i) ? wb_sel_i : '0;
   assign wb_rty_o   = 1'b0;
   assign unused_adr = ^{wb_adr_i, rd_adr, nadr};

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state    <= IDLE;
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
      end else begin
         state    <= state_nxt;
         wb_ack_o <= ack_nxt;
         wb_err_o <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (!wb_cyc_i) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:
               if (accept && !adr_oor)
                  state_nxt = (wb_cti_i == CTI_CLASSIC || wb_cti_i == CTI_END_OF_BURST) ?
                              CLASSIC : BURST;
            CLASSIC: state_nxt = IDLE;
            BURST:
               if (!(wb_stb_i && wb_ack_o) || wb_cti_i == CTI_END_OF_BURST || nadr_oor)
                  state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Next ack/err and the read port: fresh accept reads adr, bursts look ahead to nadr.
   always_comb begin
      ack_nxt = 1'b0;
      err_nxt = 1'b0;
      rd_en   = 1'b0;
      rd_clr  = 1'b0;
      rd_adr  = wb_adr_i;
      if (wb_cyc_i) begin
         case (state)
            IDLE:
               if (accept) begin
                  if (adr_oor) begin
                     err_nxt = 1'b1;
                     rd_clr  = 1'b1;
                  end else begin
                     ack_nxt = 1'b1;
                     rd_clr  = wb_we_i;
                     rd_en   = ~wb_we_i;
                  end
               end
            BURST:
               if (wb_stb_i && wb_ack_o && wb_cti_i != CTI_END_OF_BURST) begin
                  rd_adr = nadr;
                  if (nadr_oor) begin
                     err_nxt = 1'b1;
                     rd_clr  = 1'b1;
                  end else begin
                     ack_nxt = 1'b1;
                     rd_en   = 1'b1;
                  end
               end
            default: ;
         endcase
      end
   end

   peripheral_wb_ram_mem #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk  (wb_clk_i),
      .rst  (wb_rst_i),
      .we   (wr_be),
      .wadr (wb_adr_i[ADR_LSB +: IW]),
      .wdat (wb_dat_i),
      .re   (rd_en),
      .clr  (rd_clr),
      .radr (rd_adr[ADR_LSB +: IW]),
      .rdat (wb_dat_o)
   );

endmodule
